// File: rtl/lab3_divider_pkg.sv
// Shared types and constants for the lab 3 restoring divider.
package lab3_div_pkg;

   localparam int unsigned DIVIDEND_W = 8;
   localparam int unsigned DIVISOR_W  = 4;
   localparam int unsigned PARTIAL_W  = DIVISOR_W + 1;
   localparam int unsigned DIV_STEPS  = 8;
   localparam int unsigned STEP_W     = 3;

   localparam logic [DIVIDEND_W-1:0] QUOT_ZERO_DIV = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [DIVIDEND_W-1:0] quotient;
      logic [DIVISOR_W-1:0]  remainder;
      logic                  div_by_zero;
   } div_result_t;

endpackage

// File: rtl/lab3_divider_if.sv
// Start/done request and result bus between the lab 3 datapath and the divider.
interface lab3_divider_if;
   import lab3_div_pkg::*;

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );

endinterface

// File: rtl/lab3_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
   import lab3_div_pkg::*;
(
   input  logic [PARTIAL_W-1:0] partial_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [PARTIAL_W-1:0] partial_out,
   output logic                 q_bit_c
);

   logic [PARTIAL_W:0] shifted;
   logic [PARTIAL_W:0] divisor_ext;

   always_comb begin
      shifted     = {partial_in, bit_in};
      divisor_ext = (PARTIAL_W + 1)'(divisor);
      q_bit_c     = (shifted >= divisor_ext);
      // partial_in < divisor on entry, so the result always fits back in PARTIAL_W bits
      partial_out = q_bit_c ? PARTIAL_W'(shifted - divisor_ext) : PARTIAL_W'(shifted);
   end

endmodule

// File: rtl/lab3_divider.sv
// Sequential 8/4 restoring divider: FSM, step counter, working and result registers.
module lab3_divider
   import lab3_div_pkg::*;
(
   input  logic           clock_in,
   input  logic           reset_n,
   lab3_divider_if.slave  bus
);

   state_t                state_q,   state_d;
   logic [STEP_W-1:0]     step_q,    step_d;
   logic [DIVIDEND_W-1:0] dq_q,      dq_d;
   logic [PARTIAL_W-1:0]  partial_q, partial_d;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   div_result_t           res_q,     res_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;

   logic [PARTIAL_W-1:0]  partial_next;
   logic                  q_bit;

   div_step u_div_step (
      .partial_in  (partial_q),
      .bit_in      (dq_q[DIVIDEND_W-1]),
      .divisor     (divisor_q),
      .partial_out (partial_next),
      .q_bit_c     (q_bit)
   );

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         dq_q      <= '0;
         partial_q <= '0;
         divisor_q <= '0;
         res_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         dq_q      <= dq_d;
         partial_q <= partial_d;
         divisor_q <= divisor_d;
         res_q     <= res_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      dq_d      = dq_q;
      partial_d = partial_q;
      divisor_d = divisor_q;
      res_d     = res_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  state_d   = RUN;
                  dq_d      = bus.dividend;
                  divisor_d = bus.divisor;
                  partial_d = '0;
                  step_d    = '0;
               end else begin
                  state_d           = DONE;
                  res_d.quotient    = QUOT_ZERO_DIV;
                  res_d.remainder   = bus.dividend[DIVISOR_W-1:0];
                  res_d.div_by_zero = 1'b1;
               end
            end
         end
         RUN: begin
            // quotient bits enter at the LSB as dividend bits leave the MSB
            dq_d      = {dq_q[DIVIDEND_W-2:0], q_bit};
            partial_d = partial_next;
            step_d    = step_q + STEP_W'(1);
            if (step_q == STEP_W'(DIV_STEPS - 1)) begin
               state_d           = DONE;
               step_d            = '0;
               res_d.quotient    = {dq_q[DIVIDEND_W-2:0], q_bit};
               res_d.remainder   = partial_next[DIVISOR_W-1:0];
               res_d.div_by_zero = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign bus.quotient    = res_q.quotient;
   assign bus.remainder   = res_q.remainder;
   assign bus.div_by_zero = res_q.div_by_zero;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_lab3_divider.sv
// Scoreboard bench for lab3_divider: expected results queued at issue, compared on done.
module tb_lab3_divider;
   import lab3_div_pkg::*;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dbz;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   exp_t sb[$];
   exp_t last_exp;

   lab3_divider_if bus_if ();

   lab3_divider dut (
      .clock_in (clk),
      .reset_n  (rst_n),
      .bus      (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [7:0] dd, input logic [3:0] dv);
      exp_t e;
      if (dv == 4'd0) begin
         e.q   = 8'hFF;
         e.r   = dd[3:0];
         e.dbz = 1'b1;
      end else begin
         e.q   = dd / {4'd0, dv};
         e.r   = 4'(dd % {4'd0, dv});
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.q   = bus_if.quotient;
      o.r   = bus_if.remainder;
      o.dbz = bus_if.div_by_zero;
      return o;
   endfunction

   // Queue the expectation, present operands, release start just after the accepting edge.
   task automatic issue(input logic [7:0] dd, input logic [3:0] dv, input bit hold);
      sb.push_back(model(dd, dv));
      @(negedge clk);
      bus_if.start    = 1'b1;
      bus_if.dividend = dd;
      bus_if.divisor  = dv;
      @(posedge clk);
      #1;
      if (!hold) bus_if.start = 1'b0;
   endtask

   // Bounded wait for done; cycles = -1 on timeout.
   task automatic wait_done(output int cycles, output int busy_cnt, output bit overlap);
      bit seen = 1'b0;
      int n = 0;
      busy_cnt = 0;
      overlap  = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (bus_if.done && bus_if.busy) overlap = 1'b1;
         if (bus_if.done) seen = 1'b1;
         else if (bus_if.busy) busy_cnt++;
      end
      cycles = seen ? n : -1;
   endtask

   task automatic test_reset();
      bus_if.start    = 1'b0;
      bus_if.dividend = '0;
      bus_if.divisor  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({bus_if.quotient, bus_if.remainder, bus_if.busy, bus_if.done, bus_if.div_by_zero} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b required all 0",
                  bus_if.quotient, bus_if.remainder, bus_if.busy, bus_if.done, bus_if.div_by_zero);
      end
      vectors++;
      if (dut.state_q !== IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %0d required %0d", int'(dut.state_q), int'(IDLE));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int cyc, bcnt;
      bit ovl;
      exp_t e;
      issue(8'd200, 4'd7, 1'b0);
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 9) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d required 9", cyc);
      end
      vectors++;
      if (bcnt !== 8 || ovl) begin
         miscompares++;
         $display("FAIL basic_busy: got busy_cycles=%0d overlap=%b required 8/0", bcnt, ovl);
      end
      vectors++;
      if (observed() !== e) begin
         miscompares++;
         $display("FAIL basic_result: got %h required %h", observed(), e);
      end
      last_exp = e;
      @(negedge clk);
      vectors++;
      if (bus_if.done !== 1'b0 || observed() !== e) begin
         miscompares++;
         $display("FAIL basic_done_pulse: got done=%b res=%h required done=0 res=%h", bus_if.done, observed(), e);
      end
   endtask

   task automatic test_values();
      logic [7:0] dds [4];
      logic [3:0] dvs [4];
      int cyc, bcnt;
      bit ovl;
      exp_t e;
      dds = '{8'd143, 8'd5, 8'd255, 8'd255};
      dvs = '{4'd11,  4'd9, 4'd15,  4'd1};
      for (int i = 0; i < 4; i++) begin
         issue(dds[i], dvs[i], 1'b0);
         wait_done(cyc, bcnt, ovl);
         e = sb.pop_front();
         vectors++;
         if (cyc !== 9 || observed() !== e) begin
            miscompares++;
            $display("FAIL values_%0d_%0d: got lat=%0d res=%h required lat=9 res=%h",
                     dds[i], dvs[i], cyc, observed(), e);
         end
         last_exp = e;
      end
   endtask

   task automatic test_zero_div();
      int cyc, bcnt;
      bit ovl;
      exp_t e;
      issue(8'hA7, 4'd0, 1'b0);
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 1 || bcnt !== 0) begin
         miscompares++;
         $display("FAIL zero_div_timing: got lat=%0d busy_cycles=%0d required 1/0", cyc, bcnt);
      end
      vectors++;
      if (observed() !== e) begin
         miscompares++;
         $display("FAIL zero_div_result: got %h required %h", observed(), e);
      end
      issue(8'd9, 4'd3, 1'b0);
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 9 || observed() !== e) begin
         miscompares++;
         $display("FAIL zero_div_recover: got lat=%0d res=%h required lat=9 res=%h", cyc, observed(), e);
      end
      last_exp = e;
   endtask

   task automatic test_reset_mid();
      int cyc, bcnt, dones;
      bit ovl;
      exp_t e;
      issue(8'd200, 4'd7, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if ({bus_if.quotient, bus_if.remainder, bus_if.busy, bus_if.done, bus_if.div_by_zero} !== 15'd0
          || dut.state_q !== IDLE) begin
         miscompares++;
         $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dbz=%b state=%0d required all 0 / IDLE",
                  bus_if.quotient, bus_if.remainder, bus_if.busy, bus_if.done, bus_if.div_by_zero,
                  int'(dut.state_q));
      end
      sb.delete();
      rst_n = 1'b1;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_if.done) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done: got %0d done pulses required 0", dones);
      end
      issue(8'd100, 4'd3, 1'b0);
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 9 || observed() !== e) begin
         miscompares++;
         $display("FAIL reset_mid_after: got lat=%0d res=%h required lat=9 res=%h", cyc, observed(), e);
      end
      last_exp = e;
   endtask

   task automatic test_ignored_start();
      int cyc, bcnt, activity;
      bit ovl;
      exp_t e;
      exp_t old;
      old = last_exp;
      issue(8'd200, 4'd7, 1'b0);
      repeat (2) @(negedge clk);
      bus_if.start    = 1'b1;
      bus_if.dividend = 8'd50;
      bus_if.divisor  = 4'd5;
      @(negedge clk);
      bus_if.start = 1'b0;
      vectors++;
      if (observed() !== old || bus_if.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL ignored_hold: got res=%h busy=%b required res=%h busy=1", observed(), bus_if.busy, old);
      end
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc < 0 || observed() !== e) begin
         miscompares++;
         $display("FAIL ignored_result: got lat=%0d res=%h required res=%h", cyc, observed(), e);
      end
      last_exp = e;
      activity = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) activity++;
      end
      vectors++;
      if (activity !== 0) begin
         miscompares++;
         $display("FAIL ignored_no_second: got %0d active cycles required 0", activity);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt;
      bit ovl;
      exp_t e;
      issue(8'd60, 4'd4, 1'b1);
      wait_done(cyc, bcnt, ovl);
      e = sb.pop_front();
      vectors++;
      if (cyc !== 9 || observed() !== e) begin
         miscompares++;
         $display("FAIL b2b_first: got lat=%0d res=%h required lat=9 res=%h", cyc, observed(), e);
      end
      last_exp = e;
      bus_if.dividend = 8'd77;
      bus_if.divisor  = 4'd6;
      sb.push_back(model(8'd77, 4'd6));
      @(negedge clk);
      vectors++;
      if (observed() !== last_exp) begin
         miscompares++;
         $display("FAIL b2b_hold: got %h required %h", observed(), last_exp);
      end
      wait_done(cyc, bcnt, ovl);
      bus_if.start = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (cyc < 0 || ovl || observed() !== e) begin
         miscompares++;
         $display("FAIL b2b_second: got lat=%0d overlap=%b res=%h required res=%h", cyc, ovl, observed(), e);
      end
      last_exp = e;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_exp    = '0;
      rst_n       = 1'b0;
      bus_if.start    = 1'b0;
      bus_if.dividend = '0;
      bus_if.divisor  = '0;
      test_reset();
      test_basic();
      test_values();
      test_zero_div();
      test_reset_mid();
      test_ignored_start();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
